// File: rtl/display_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl_pkg : shared constants, FSM encoding, leading-zero mask. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package display_scan_ctrl_pkg;

  localparam int c_bcd_w      = 4;
  localparam int c_max_digits = 8;

  typedef logic [1:0] state_t;
  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_blank = 2'd1;
  localparam state_t c_st_on    = 2'd2;

  // Bit i set when digit i and every digit above it are zero; digit 0 never set.
  function automatic logic [c_max_digits-1:0] lz_mask(
    input logic [c_bcd_w*c_max_digits-1:0] digits,
    input int                              num
  );
    logic zeros_above;
    lz_mask     = '0;
    zeros_above = 1'b1;
    for (int i = c_max_digits - 1; i > 0; i--) begin
      if (i < num) begin
        zeros_above = zeros_above & (digits[c_bcd_w*i +: c_bcd_w] == '0);
        lz_mask[i]  = zeros_above;
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl_if : digit-word load handshake between producer and scanner. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface display_scan_ctrl_if
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                          load;
  logic                          load_ready;
  logic [c_bcd_w*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]         dots_in;

  modport master (output load, digits_in, dots_in, input load_ready);
  modport slave  (input load, digits_in, dots_in, output load_ready);
endinterface

`default_nettype wire

// File: rtl/display_scan_ctrl_scan_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen : slot counter giving dead-time and slot-end strobes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scan_tick_gen #(
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_dead_end,
  output logic o_slot_end
);
  localparam int                 c_cnt_w     = $clog2(SLOT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_dead_last = c_cnt_w'(DEAD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_slot_last = c_cnt_w'(SLOT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Only the FSM returns the counter to zero; it never free-runs past the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= r_cnt + c_cnt_w'(1);
  end

  assign o_dead_end = (r_cnt == c_dead_last);
  assign o_slot_end = (r_cnt == c_slot_last);

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl : double-buffered multiplexed 7-segment digit scanner. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  display_scan_ctrl_if.slave    src,
  input  logic                  blank_lz,
  output logic [c_bcd_w-1:0]    digit_code,
  output logic                  digit_dot,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_done
);
  localparam int                    c_idx_w    = $clog2(NUM_DIGITS);
  localparam int                    c_word_w   = c_bcd_w * NUM_DIGITS;
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_sel_one  = NUM_DIGITS'(1);

  state_t                           r_state, w_state_nxt;
  logic [c_idx_w-1:0]               r_idx, w_idx_nxt;
  logic [c_word_w-1:0]              r_act_digits, r_pend_digits, w_act_digits_nxt;
  logic [NUM_DIGITS-1:0]            r_act_dots, r_pend_dots, w_act_dots_nxt;
  logic                             r_pend_valid, r_load_ready;
  logic                             w_dead_end, w_slot_end, w_clr;
  logic                             w_wrap, w_boundary, w_transfer, w_accept;
  logic [c_bcd_w-1:0]               w_code_nxt;
  logic                             w_dot_nxt;
  logic [NUM_DIGITS-1:0]            w_sel_nxt, w_lz_mask;
  logic [c_bcd_w*c_max_digits-1:0]  w_act_ext;

  scan_tick_gen #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .o_dead_end (w_dead_end),
    .o_slot_end (w_slot_end)
  );

  assign w_wrap     = enable && (r_state == c_st_on) && w_slot_end && (r_idx == c_idx_last);
  assign w_boundary = (enable && (r_state == c_st_idle)) || w_wrap;
  assign w_transfer = w_boundary && r_pend_valid;
  assign w_accept   = src.load && !r_pend_valid;
  assign w_clr      = !enable || (r_state == c_st_idle) || ((r_state == c_st_on) && w_slot_end);

  always_comb begin
    w_act_ext                 = '0;
    w_act_ext[c_word_w-1:0]   = r_act_digits;
    w_lz_mask                 = NUM_DIGITS'(lz_mask(w_act_ext, NUM_DIGITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:  w_state_nxt = c_st_blank;
        c_st_blank: if (w_dead_end) w_state_nxt = c_st_on;
        c_st_on:    if (w_slot_end) w_state_nxt = c_st_blank;
        default:    w_state_nxt = c_st_idle;
      endcase
    end
  end

  // Code and dot latch on BLANK entry (from the post-transfer buffer) so they
  // settle before the select rises; select is decided once per slot on ON entry.
  always_comb begin
    w_idx_nxt = r_idx;
    if (!enable || (r_state == c_st_idle))
      w_idx_nxt = '0;
    else if ((r_state == c_st_on) && w_slot_end)
      w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
    w_act_digits_nxt = w_transfer ? r_pend_digits : r_act_digits;
    w_act_dots_nxt   = w_transfer ? r_pend_dots   : r_act_dots;
    w_code_nxt       = digit_code;
    w_dot_nxt        = digit_dot;
    if ((r_state != c_st_blank) && (w_state_nxt == c_st_blank)) begin
      w_code_nxt = w_act_digits_nxt[c_bcd_w*int'(w_idx_nxt) +: c_bcd_w];
      w_dot_nxt  = w_act_dots_nxt[w_idx_nxt];
    end
    w_sel_nxt = '0;
    if (w_state_nxt == c_st_on) begin
      if (r_state == c_st_on)
        w_sel_nxt = digit_sel;
      else if (!(blank_lz && w_lz_mask[r_idx]))
        w_sel_nxt = c_sel_one << r_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_act_digits  <= '0;
      r_act_dots    <= '0;
      r_pend_digits <= '0;
      r_pend_dots   <= '0;
      r_pend_valid  <= 1'b0;
      r_load_ready  <= 1'b1;
    end else begin
      r_idx        <= w_idx_nxt;
      r_act_digits <= w_act_digits_nxt;
      r_act_dots   <= w_act_dots_nxt;
      if (w_transfer) begin
        r_pend_valid <= 1'b0;
        r_load_ready <= 1'b1;
      end else if (w_accept) begin
        r_pend_digits <= src.digits_in;
        r_pend_dots   <= src.dots_in;
        r_pend_valid  <= 1'b1;
        r_load_ready  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_code <= '0;
      digit_dot  <= 1'b0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      digit_code <= w_code_nxt;
      digit_dot  <= w_dot_nxt;
      digit_sel  <= w_sel_nxt;
      frame_done <= w_wrap;
    end
  end

  assign src.load_ready = r_load_ready;

endmodule

`default_nettype wire
